// File: rtl/i2c_target.sv
// SCCB/I2C target: oversampled SCL/SDA, START/STOP decode, 7-bit address match,
// register-pointer/data writes and auto-incrementing reads from a host lookup port.
module i2c_target #(
    parameter logic [6:0] DEV_ADDR = 7'h21,
    parameter int         FILT     = 2
) (
    input  logic       State_clk,
    input  logic       rst,
    inout  wire        scl_io,
    inout  wire        sda_io,
    output logic       wr_valid,
    output logic [7:0] wr_reg,
    output logic [7:0] wr_data,
    output logic [7:0] rd_reg,
    input  logic [7:0] rd_data,
    output logic       busy
);

    localparam int CW = $clog2(FILT + 1) + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_WAIT_STOP
    } state_t;

    logic [1:0] line_pin;
    logic [1:0] line_filt;

    // Bit 0 is SCL, bit 1 is SDA; SCL is only ever sampled.
    assign line_pin = {sda_io, scl_io};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_line
            logic          sync1_q;
            logic          sync2_q;
            logic          filt_q;
            logic [CW-1:0] cnt_q;

            // Filtered level flips only after FILT+1 consecutive differing samples.
            always_ff @(posedge State_clk) begin
                if (rst) begin
                    sync1_q <= 1'b1;
                    sync2_q <= 1'b1;
                    filt_q  <= 1'b1;
                    cnt_q   <= '0;
                end else begin
                    sync1_q <= line_pin[gi];
                    sync2_q <= sync1_q;
                    if (sync2_q == filt_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CW'(FILT)) begin
                        filt_q <= sync2_q;
                        cnt_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
            end

            assign line_filt[gi] = filt_q;
        end
    endgenerate

    state_t     state_q;
    logic       scl_prev_q;
    logic       sda_prev_q;
    logic       sda_low_q;
    logic       wr_valid_q;
    logic [7:0] wr_reg_q;
    logic [7:0] wr_data_q;
    logic [7:0] ptr_q;
    logic       busy_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] shift_q;
    logic       byte_done_q;
    logic       rw_q;

    logic       scl_f;
    logic       sda_f;
    logic       scl_rise;
    logic       scl_fall;
    logic       start_ev;
    logic       stop_ev;
    logic [7:0] shift_d;

    assign scl_f    = line_filt[0];
    assign sda_f    = line_filt[1];
    assign scl_rise = scl_f & ~scl_prev_q;
    assign scl_fall = ~scl_f & scl_prev_q;
    assign start_ev = sda_prev_q & ~sda_f & scl_f;
    assign stop_ev  = ~sda_prev_q & sda_f & scl_f;
    assign shift_d  = {shift_q[6:0], sda_f};

    always_ff @(posedge State_clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            scl_prev_q  <= 1'b1;
            sda_prev_q  <= 1'b1;
            sda_low_q   <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_reg_q    <= 8'h00;
            wr_data_q   <= 8'h00;
            ptr_q       <= 8'h00;
            busy_q      <= 1'b0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            byte_done_q <= 1'b0;
            rw_q        <= 1'b0;
        end else begin
            scl_prev_q <= scl_f;
            sda_prev_q <= sda_f;
            wr_valid_q <= 1'b0;
            if (stop_ev) begin
                state_q   <= S_IDLE;
                sda_low_q <= 1'b0;
                busy_q    <= 1'b0;
            end else if (start_ev) begin
                state_q     <= S_ADDR;
                bit_cnt_q   <= 3'd0;
                sda_low_q   <= 1'b0;
                byte_done_q <= 1'b0;
            end else begin
                case (state_q)
                    S_ADDR, S_REG, S_WDATA: begin
                        if (scl_rise && !byte_done_q) begin
                            shift_q   <= shift_d;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                byte_done_q <= 1'b1;
                                if (state_q == S_ADDR && shift_d[7:1] != DEV_ADDR) begin
                                    state_q <= S_WAIT_STOP;
                                end
                            end
                        end else if (scl_fall && byte_done_q) begin
                            byte_done_q <= 1'b0;
                            sda_low_q   <= 1'b1;
                            if (state_q == S_ADDR) begin
                                busy_q  <= 1'b1;
                                rw_q    <= shift_q[0];
                                state_q <= S_ADDR_ACK;
                            end else if (state_q == S_REG) begin
                                ptr_q   <= shift_q;
                                state_q <= S_REG_ACK;
                            end else begin
                                wr_valid_q <= 1'b1;
                                wr_reg_q   <= ptr_q;
                                wr_data_q  <= shift_q;
                                ptr_q      <= ptr_q + 8'd1;
                                state_q    <= S_WDATA_ACK;
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt_q <= 3'd0;
                            if (rw_q) begin
                                shift_q   <= rd_data;
                                sda_low_q <= ~rd_data[7];
                                state_q   <= S_RDATA;
                            end else begin
                                sda_low_q <= 1'b0;
                                state_q   <= S_REG;
                            end
                        end
                    end
                    S_REG_ACK, S_WDATA_ACK: begin
                        if (scl_fall) begin
                            sda_low_q <= 1'b0;
                            bit_cnt_q <= 3'd0;
                            state_q   <= S_WDATA;
                        end
                    end
                    S_RDATA: begin
                        // The MSB went out on entry; each fall shifts out the next bit.
                        if (scl_fall) begin
                            if (bit_cnt_q == 3'd7) begin
                                sda_low_q <= 1'b0;
                                ptr_q     <= ptr_q + 8'd1;
                                bit_cnt_q <= 3'd0;
                                state_q   <= S_RDATA_ACK;
                            end else begin
                                sda_low_q <= ~shift_q[6];
                                shift_q   <= {shift_q[6:0], 1'b0};
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                            end
                        end
                    end
                    S_RDATA_ACK: begin
                        if (scl_rise) begin
                            if (sda_f) begin
                                state_q <= S_WAIT_STOP;
                            end else begin
                                byte_done_q <= 1'b1;
                            end
                        end else if (scl_fall && byte_done_q) begin
                            byte_done_q <= 1'b0;
                            shift_q     <= rd_data;
                            sda_low_q   <= ~rd_data[7];
                            bit_cnt_q   <= 3'd0;
                            state_q     <= S_RDATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sda_io   = sda_low_q ? 1'b0 : 1'bz;
    assign wr_valid = wr_valid_q;
    assign wr_reg   = wr_reg_q;
    assign wr_data  = wr_data_q;
    assign rd_reg   = ptr_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bus tasks act as initiator, observed bus bits and
// wr_valid beats are scoreboarded against expectations queued with the stimulus.
module tb_i2c_target;

    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_drv;
    logic       tb_sda_low;
    wire        scl_io;
    wire        sda_io;
    logic       wr_valid;
    logic [7:0] wr_reg;
    logic [7:0] wr_data;
    logic [7:0] rd_reg;
    logic [7:0] rd_data;
    logic       busy;

    always #5 clk = ~clk;

    assign scl_io  = scl_drv;
    assign sda_io  = tb_sda_low ? 1'b0 : 1'bz;
    pullup (sda_io);
    assign rd_data = ~rd_reg;

    i2c_target #(.DEV_ADDR(7'h21), .FILT(2)) dut (
        .State_clk(clk),
        .rst      (rst),
        .scl_io   (scl_io),
        .sda_io   (sda_io),
        .wr_valid (wr_valid),
        .wr_reg   (wr_reg),
        .wr_data  (wr_data),
        .rd_reg   (rd_reg),
        .rd_data  (rd_data),
        .busy     (busy)
    );

    typedef struct {
        string name;
        int    val;
    } item_t;

    typedef struct {
        logic [7:0] r;
        logic [7:0] d;
    } wr_t;

    item_t exp_bus_q[$];
    item_t obs_bus_q[$];
    wr_t   exp_wr_q[$];
    int    checks = 0;
    int    failures = 0;
    int    wr_seen = 0;
    int    dut_low_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_bus(input string name, input int val);
        item_t it;
        it.name = name;
        it.val  = val;
        exp_bus_q.push_back(it);
    endtask

    task automatic expect_wr(input logic [7:0] r, input logic [7:0] d);
        wr_t w;
        w.r = r;
        w.d = d;
        exp_wr_q.push_back(w);
    endtask

    // Bus-side monitor: pairs each observed bus value with the oldest expectation.
    always @(negedge clk) begin
        while (obs_bus_q.size() > 0) begin
            item_t o;
            item_t e;
            o = obs_bus_q.pop_front();
            if (exp_bus_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL bus_unexpected %s actual=0x%0h required=none", o.name, o.val);
            end else begin
                e = exp_bus_q.pop_front();
                chk(e.name, o.val, e.val);
                $display("bus %s observed=0x%0h", e.name, o.val);
            end
        end
    end

    always @(negedge clk) begin
        if (wr_valid === 1'b1) begin
            wr_seen++;
            if (exp_wr_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wr_unexpected actual=(0x%0h,0x%0h) required=none", wr_reg, wr_data);
            end else begin
                wr_t w;
                w = exp_wr_q.pop_front();
                chk("wr_reg", int'(wr_reg), int'(w.r));
                chk("wr_data", int'(wr_data), int'(w.d));
                $display("wr reg=0x%0h data=0x%0h", wr_reg, wr_data);
            end
        end
        if (sda_io === 1'b0 && !tb_sda_low) dut_low_cnt++;
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        tb_sda_low = 1'b1;
        wait_clk(2 * Q);
        scl_drv = 1'b0;
    endtask

    task automatic bus_rstart();
        wait_clk(Q);
        tb_sda_low = 1'b0;
        wait_clk(Q);
        scl_drv = 1'b1;
        wait_clk(2 * Q);
        tb_sda_low = 1'b1;
        wait_clk(2 * Q);
        scl_drv = 1'b0;
    endtask

    task automatic bus_stop();
        wait_clk(Q);
        tb_sda_low = 1'b1;
        wait_clk(Q);
        scl_drv = 1'b1;
        wait_clk(2 * Q);
        tb_sda_low = 1'b0;
        wait_clk(2 * Q);
    endtask

    // One SCL period starting just after a fall; optional 1-cycle low glitch while high.
    task automatic clk_bit(input logic val, input logic glitch, output logic sampled);
        wait_clk(Q);
        tb_sda_low = ~val;
        wait_clk(Q);
        scl_drv = 1'b1;
        if (glitch) begin
            wait_clk(4);
            scl_drv = 1'b0;
            wait_clk(1);
            scl_drv = 1'b1;
            wait_clk(Q - 5);
        end else begin
            wait_clk(Q);
        end
        sampled = sda_io;
        wait_clk(Q);
        scl_drv = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, input string name, input int glitch_bit);
        logic  s;
        item_t it;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], glitch_bit == i, s);
        clk_bit(1'b1, 1'b0, s);
        it.name = name;
        it.val  = int'(s);
        obs_bus_q.push_back(it);
    endtask

    task automatic read_byte(input logic nack, input string name);
        logic [7:0] v;
        logic       s;
        item_t      it;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, 1'b0, s);
            v[i] = s;
        end
        it.name = name;
        it.val  = int'(v);
        obs_bus_q.push_back(it);
        clk_bit(nack, 1'b0, s);
    endtask

    initial begin
        int wr_snap;
        rst        = 1'b1;
        scl_drv    = 1'b1;
        tb_sda_low = 1'b0;
        wait_clk(5);
        rst = 1'b0;
        wait_clk(2);
        chk("rst_sda", int'(sda_io), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rd_reg", int'(rd_reg), 0);
        chk("rst_wr_valid", int'(wr_valid), 0);

        // Single write: pointer 0x12, data 0x80.
        expect_bus("t1_addr_ack", 0);
        expect_bus("t1_reg_ack", 0);
        expect_bus("t1_data_ack", 0);
        expect_wr(8'h12, 8'h80);
        bus_start();
        write_byte(8'h42, "t1_addr_ack", -1);
        chk("t1_busy", int'(busy), 1);
        write_byte(8'h12, "t1_reg_ack", -1);
        write_byte(8'h80, "t1_data_ack", -1);
        bus_stop();
        chk("t1_busy_after", int'(busy), 0);
        chk("t1_ptr", int'(rd_reg), 8'h13);

        // Burst write across pointer wrap.
        expect_bus("t2_addr_ack", 0);
        expect_bus("t2_reg_ack", 0);
        expect_bus("t2_d0_ack", 0);
        expect_bus("t2_d1_ack", 0);
        expect_bus("t2_d2_ack", 0);
        expect_wr(8'hFE, 8'hA1);
        expect_wr(8'hFF, 8'hA2);
        expect_wr(8'h00, 8'hA3);
        bus_start();
        write_byte(8'h42, "t2_addr_ack", -1);
        write_byte(8'hFE, "t2_reg_ack", -1);
        write_byte(8'hA1, "t2_d0_ack", -1);
        write_byte(8'hA2, "t2_d1_ack", -1);
        write_byte(8'hA3, "t2_d2_ack", -1);
        bus_stop();
        chk("t2_ptr", int'(rd_reg), 8'h01);

        // Pointer write, repeated START, two-byte read (rd_data = ~rd_reg).
        expect_bus("t3_addr_ack", 0);
        expect_bus("t3_reg_ack", 0);
        expect_bus("t3_raddr_ack", 0);
        expect_bus("t3_rd0", 8'hF5);
        expect_bus("t3_rd1", 8'hF4);
        bus_start();
        write_byte(8'h42, "t3_addr_ack", -1);
        write_byte(8'h0A, "t3_reg_ack", -1);
        bus_rstart();
        write_byte(8'h43, "t3_raddr_ack", -1);
        read_byte(1'b0, "t3_rd0");
        read_byte(1'b1, "t3_rd1");
        wait_clk(8);
        chk("t3_sda_released", int'(sda_io), 1);
        chk("t3_busy_pre_stop", int'(busy), 1);
        bus_stop();
        chk("t3_busy_after", int'(busy), 0);
        chk("t3_ptr", int'(rd_reg), 8'h0C);

        // Foreign address: no ACK, no write, not busy; then a normal access.
        dut_low_cnt = 0;
        wr_snap = wr_seen;
        expect_bus("t4_addr_nack", 1);
        expect_bus("t4_data_nack", 1);
        bus_start();
        write_byte(8'h60, "t4_addr_nack", -1);
        chk("t4_busy", int'(busy), 0);
        write_byte(8'h12, "t4_data_nack", -1);
        bus_stop();
        chk("t4_sda_never_low", dut_low_cnt, 0);
        chk("t4_no_wr", wr_seen - wr_snap, 0);
        expect_bus("t4_addr2_ack", 0);
        expect_bus("t4_reg2_ack", 0);
        bus_start();
        write_byte(8'h42, "t4_addr2_ack", -1);
        write_byte(8'h20, "t4_reg2_ack", -1);
        bus_stop();
        chk("t4_ptr", int'(rd_reg), 8'h20);

        // SCL glitch inside the register byte must be filtered out.
        expect_bus("t5_addr_ack", 0);
        expect_bus("t5_reg_ack", 0);
        expect_bus("t5_data_ack", 0);
        expect_wr(8'h5A, 8'h33);
        bus_start();
        write_byte(8'h42, "t5_addr_ack", -1);
        write_byte(8'h5A, "t5_reg_ack", 3);
        write_byte(8'h33, "t5_data_ack", -1);
        bus_stop();
        chk("t5_ptr", int'(rd_reg), 8'h5B);

        // Reset while the target drives a 0 data bit during a read.
        expect_bus("t6_reg_addr_ack", 0);
        expect_bus("t6_reg_ack", 0);
        expect_bus("t6_raddr_ack", 0);
        bus_start();
        write_byte(8'h42, "t6_reg_addr_ack", -1);
        write_byte(8'h80, "t6_reg_ack", -1);
        bus_stop();
        bus_start();
        write_byte(8'h43, "t6_raddr_ack", -1);
        wait_clk(Q);
        chk("t6_sda_driven", int'(sda_io), 0);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        chk("t6_sda_rel", int'(sda_io), 1);
        chk("t6_ptr_rst", int'(rd_reg), 0);
        chk("t6_busy_rst", int'(busy), 0);
        bus_stop();
        expect_bus("t6_addr2_ack", 0);
        expect_bus("t6_rd", 8'hFF);
        bus_start();
        write_byte(8'h43, "t6_addr2_ack", -1);
        read_byte(1'b1, "t6_rd");
        bus_stop();
        chk("t6_ptr_after", int'(rd_reg), 8'h01);

        wait_clk(4);
        chk("wr_queue_drained", exp_wr_q.size(), 0);
        chk("bus_queue_drained", exp_bus_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
